detector_readout_sequencer: RTL and testbench

Sequences the detector readout path: arms on the first non-zero detector word, accumulates (bitwise OR) the detector bus over a programmable coincidence window, timestamps the event and delivers it as one AXI4-Stream beat. A programmable dead time follows each delivered event. Sits between the detector front-end bus and the event DMA/FIFO, replacing free-running window logic with an enable-gated, back-pressure-aware controller.

---
 rtl/detector_readout_sequencer.sv | 158 +++++++++++++++
 tb/tb_detector_readout_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/detector_readout_sequencer.sv
// detector_readout_sequencer
//
// Detector readout controller. Arms on the first non-zero detector word,
// ORs the detector bus over a programmable coincidence window, timestamps
// the event and delivers it as one AXI4-Stream beat. A programmable dead
// time follows every delivered event.
//
// Ports
//   aclk, aresetn      clock (rising edge) and asynchronous active-low reset
//   enable             run enable
//   cfg_window         window length W, window spans W+2 detector samples
//   cfg_dead           dead time D, dead state lasts D+1 cycles
//   din                detector hit bus, any set bit is a hit
//   m_axis_tdata       {timestamp, accumulated hits}
//   m_axis_tvalid      event beat valid
//   m_axis_tready      downstream ready
//   busy               high in WINDOW, SEND, DEAD
//   lost_cnt           saturating count of hit cycles ignored in SEND/DEAD
//
// Build option
//   DETECTOR_SEQ_LOST_CNT_EN  defined: lost_cnt implemented;
//                             undefined: lost_cnt tied to zero.
//
// state  | meaning
// IDLE   | disabled, waiting for enable
// ARMED  | waiting for first non-zero detector word
// WINDOW | accumulating hits, counting window samples
// SEND   | event beat presented, waiting for handshake
// DEAD   | dead time after delivery, hits are counted as lost

module detector_readout_sequencer #(
    parameter int DATA_WIDTH = 66,
    parameter int TS_WIDTH   = 32,
    parameter int CNTR_WIDTH = 8
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic                           enable,
    input  logic [CNTR_WIDTH-1:0]          cfg_window,
    input  logic [CNTR_WIDTH-1:0]          cfg_dead,
    input  logic [DATA_WIDTH-1:0]          din,
    output logic [TS_WIDTH+DATA_WIDTH-1:0] m_axis_tdata,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           busy,
    output logic [15:0]                    lost_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARMED  = 3'd1,
        S_WINDOW = 3'd2,
        S_SEND   = 3'd3,
        S_DEAD   = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [TS_WIDTH-1:0]     ts_q, ts_d;
    logic [TS_WIDTH-1:0]     ts_reg_q, ts_reg_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [CNTR_WIDTH-1:0]   cntr_q, cntr_d;
    logic                    tvalid_q, tvalid_d;
    logic                    busy_q, busy_d;
    logic                    hit;

    assign hit = |din;

    always_comb begin
        state_d  = state_q;
        ts_d     = ts_q + TS_WIDTH'(1);
        ts_reg_d = ts_reg_q;
        data_d   = data_q;
        cntr_d   = cntr_q;
        unique case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (hit) begin
                    data_d   = din;
                    ts_reg_d = ts_q;
                    cntr_d   = '0;
                    state_d  = S_WINDOW;
                end
            end
            S_WINDOW: begin
                data_d = data_q | din;
                cntr_d = cntr_q + CNTR_WIDTH'(1);
                // compare on the pre-increment value so W = max never needs the wrapped count
                if (cntr_q >= cfg_window) state_d = S_SEND;
            end
            S_SEND: begin
                if (m_axis_tready) begin
                    cntr_d  = '0;
                    state_d = S_DEAD;
                end
            end
            S_DEAD: begin
                cntr_d = cntr_q + CNTR_WIDTH'(1);
                if (cntr_q >= cfg_dead) state_d = enable ? S_ARMED : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // outputs are registered from the next state so they are flop outputs
        tvalid_d = (state_d == S_SEND);
        busy_d   = (state_d == S_WINDOW) || (state_d == S_SEND) || (state_d == S_DEAD);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= S_IDLE;
            ts_q     <= '0;
            ts_reg_q <= '0;
            data_q   <= '0;
            cntr_q   <= '0;
            tvalid_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ts_q     <= ts_d;
            ts_reg_q <= ts_reg_d;
            data_q   <= data_d;
            cntr_q   <= cntr_d;
            tvalid_q <= tvalid_d;
            busy_q   <= busy_d;
        end
    end

    assign m_axis_tdata  = {ts_reg_q, data_q};
    assign m_axis_tvalid = tvalid_q;
    assign busy          = busy_q;

`ifdef DETECTOR_SEQ_LOST_CNT_EN
    logic [15:0] lost_q, lost_d;

    always_comb begin
        lost_d = lost_q;
        if (((state_q == S_SEND) || (state_q == S_DEAD)) && hit && (lost_q != 16'hFFFF)) begin
            lost_d = lost_q + 16'd1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            lost_q <= '0;
        end else begin
            lost_q <= lost_d;
        end
    end

    assign lost_cnt = lost_q;
`else
    assign lost_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_detector_readout_sequencer.sv
module tb_detector_readout_sequencer;

    localparam int DW  = 66;
    localparam int TW  = 32;
    localparam int CW  = 8;
    localparam int TDW = TW + DW;

    logic            aclk = 1'b0;
    logic            aresetn;
    logic            enable;
    logic [CW-1:0]   cfg_window;
    logic [CW-1:0]   cfg_dead;
    logic [DW-1:0]   din;
    logic [TDW-1:0]  m_axis_tdata;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic            busy;
    logic [15:0]     lost_cnt;

    detector_readout_sequencer #(
        .DATA_WIDTH(DW),
        .TS_WIDTH  (TW),
        .CNTR_WIDTH(CW)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .enable       (enable),
        .cfg_window   (cfg_window),
        .cfg_dead     (cfg_dead),
        .din          (din),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .busy         (busy),
        .lost_cnt     (lost_cnt)
    );

    always #5 aclk = ~aclk;

    int checks   = 0;
    int failures = 0;
    int exp_lost = 0;

    logic [TDW-1:0] exp_q[$];
    logic [TW-1:0]  ts_m;
    logic           stall_prev = 1'b0;
    logic [TDW-1:0] prev_data;

    localparam logic [DW-1:0] ONES = {DW{1'b1}};

    typedef struct {
        logic [CW-1:0] win;
        logic [CW-1:0] dead;
        logic [DW-1:0] d0;
        logic [DW-1:0] mid;
        logic [DW-1:0] d1;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lost_exp();
`ifdef DETECTOR_SEQ_LOST_CNT_EN
        return (exp_lost > 65535) ? 16'hFFFF : exp_lost[15:0];
`else
        return 16'd0;
`endif
    endfunction

    // free-running timestamp reference
    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) ts_m <= '0;
        else          ts_m <= ts_m + 32'd1;
    end

    // scoreboard monitor: sampled mid-cycle
    always @(negedge aclk) begin
        logic [TDW-1:0] e;
        if (aresetn) begin
            if (stall_prev) begin
                check("hold_valid", 128'(m_axis_tvalid), 128'(1'b1));
                check("hold_data", 128'(m_axis_tdata), 128'(prev_data));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                check("beat_expected", 128'(exp_q.size() != 0), 128'(1'b1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("beat_data", 128'(m_axis_tdata), 128'(e));
                end
            end
            stall_prev = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 2000) begin
            cyc();
            n++;
        end
        check("wait_idle_timeout", 128'(busy), 128'(1'b0));
    endtask

    // leaves the bench in a cycle where the DUT is ARMED
    task automatic arm();
        enable = 1'b1;
        din    = '0;
        wait_idle();
        cyc();
    endtask

    task automatic push_exp(input logic [DW-1:0] d);
        exp_q.push_back({ts_m, d});
    endtask

    initial begin
        vecs[0] = '{win: 8'd3,   dead: 8'd2, d0: 66'h1,                    mid: 66'h0,  d1: 66'h2,       exp: 66'h3};
        vecs[1] = '{win: 8'd0,   dead: 8'd0, d0: 66'h2_0000_0000_0000_0000, mid: 66'h0,  d1: 66'h0,       exp: 66'h2_0000_0000_0000_0000};
        vecs[2] = '{win: 8'd1,   dead: 8'd5, d0: 66'h3_0000_0000_0000_0000, mid: 66'h10, d1: 66'h1,       exp: 66'h3_0000_0000_0000_0011};
        vecs[3] = '{win: 8'd7,   dead: 8'd1, d0: 66'h100,                  mid: 66'h0,  d1: 66'h200_0000, exp: 66'h200_0100};
        vecs[4] = '{win: 8'd2,   dead: 8'd4, d0: 66'h1,                    mid: 66'h1,  d1: 66'h1,       exp: 66'h1};
        vecs[5] = '{win: 8'd255, dead: 8'd0, d0: 66'h1,                    mid: ONES,   d1: 66'h1,       exp: ONES};

        aresetn       = 1'b0;
        enable        = 1'b0;
        cfg_window    = '0;
        cfg_dead      = 8'd1;
        din           = '0;
        m_axis_tready = 1'b1;
        #2;
        check("rst_tvalid", 128'(m_axis_tvalid), 128'(1'b0));
        check("rst_tdata", 128'(m_axis_tdata), 128'(0));
        check("rst_busy", 128'(busy), 128'(1'b0));
        check("rst_lost", 128'(lost_cnt), 128'(0));
        cyc();
        cyc();
        aresetn = 1'b1;
        cyc();
        cyc();

        // enable timing: hits in IDLE and in the enable cycle are ignored
        din = 66'h5;
        cyc();
        din    = 66'h5;
        enable = 1'b1;
        check("en_idle_busy", 128'(busy), 128'(1'b0));
        cyc();
        din = 66'hA0;
        push_exp(66'hA0);
        check("en_armed_busy", 128'(busy), 128'(1'b0));
        cyc();
        din = '0;
        check("en_window_busy", 128'(busy), 128'(1'b1));
        cyc();
        check("en_beat_valid", 128'(m_axis_tvalid), 128'(1'b1));

        // table-driven events
        foreach (vecs[i]) begin
            cfg_window    = vecs[i].win;
            cfg_dead      = vecs[i].dead;
            m_axis_tready = 1'b1;
            arm();
            din = vecs[i].d0;
            push_exp(vecs[i].exp);
            for (int k = 1; k <= int'(vecs[i].win) + 1; k++) begin
                cyc();
                if (k == int'(vecs[i].win) + 1) begin
                    din = vecs[i].d1;
                    check("vec_valid_early", 128'(m_axis_tvalid), 128'(1'b0));
                end else begin
                    din = vecs[i].mid;
                end
            end
            cyc();
            din = '0;
            check("vec_valid_on_time", 128'(m_axis_tvalid), 128'(1'b1));
            for (int d = 0; d <= int'(vecs[i].dead); d++) begin
                cyc();
                check("vec_dead_busy", 128'(busy), 128'(1'b1));
            end
            cyc();
            check("vec_rearmed", 128'(busy), 128'(1'b0));
        end
        check("vec_lost", 128'(lost_cnt), 128'(lost_exp()));

        // back-pressure: ten stalled cycles, hits while stalled and in dead time
        cfg_window = 8'd0;
        cfg_dead   = 8'd3;
        arm();
        din           = 66'h2_0000_0000_0000_0000;
        m_axis_tready = 1'b0;
        push_exp(66'h2_0000_0000_0000_0000);
        for (int c = 1; c <= 16; c++) begin
            cyc();
            din           = (c == 3 || c == 5 || c == 6 || c == 13) ? 66'h1 : 66'h0;
            m_axis_tready = (c >= 12);
            if (c == 1) check("bp_valid_early", 128'(m_axis_tvalid), 128'(1'b0));
            if (c == 2) check("bp_valid", 128'(m_axis_tvalid), 128'(1'b1));
            if (c == 11) check("bp_still_valid", 128'(m_axis_tvalid), 128'(1'b1));
        end
        exp_lost += 4;
        cyc();
        check("bp_lost", 128'(lost_cnt), 128'(lost_exp()));

        // disable mid-window: full beat, then IDLE, no re-arm
        cfg_window = 8'd10;
        cfg_dead   = 8'd2;
        arm();
        din = 66'h40;
        push_exp(66'h40);
        for (int c = 1; c <= 20; c++) begin
            cyc();
            din    = (c >= 16) ? 66'hFF : 66'h0;
            enable = (c < 2);
            if (c == 11) check("dis_valid_early", 128'(m_axis_tvalid), 128'(1'b0));
            if (c == 12) check("dis_valid", 128'(m_axis_tvalid), 128'(1'b1));
            if (c == 15) check("dis_dead_busy", 128'(busy), 128'(1'b1));
            if (c >= 16) check("dis_idle", 128'(busy), 128'(1'b0));
        end
        cyc();
        din = '0;
        check("dis_lost", 128'(lost_cnt), 128'(lost_exp()));

        // lost counter accumulation and saturation with continuous hits
        cfg_window = 8'd0;
        cfg_dead   = 8'd255;
        arm();
`ifdef DETECTOR_SEQ_LOST_CNT_EN
        for (int e = 0; e < 273; e++) begin
`else
        for (int e = 0; e < 8; e++) begin
`endif
            din = ONES;
            push_exp(ONES);
            repeat (259) cyc();
            exp_lost += 257;
            check("sat_lost", 128'(lost_cnt), 128'(lost_exp()));
        end
        din = '0;
        cyc();

        // asynchronous reset while a beat is stalled
        arm();
        din           = 66'h8;
        m_axis_tready = 1'b0;
        push_exp(66'h8);
        cyc();
        din = '0;
        cyc();
        check("rst_pre_valid", 128'(m_axis_tvalid), 128'(1'b1));
        #3;
        aresetn = 1'b0;
        #1;
        check("rst_mid_tvalid", 128'(m_axis_tvalid), 128'(1'b0));
        check("rst_mid_busy", 128'(busy), 128'(1'b0));
        check("rst_mid_lost", 128'(lost_cnt), 128'(0));
        check("rst_mid_tdata", 128'(m_axis_tdata), 128'(0));
        exp_q.delete();
        exp_lost      = 0;
        enable        = 1'b0;
        m_axis_tready = 1'b1;
        cyc();
        cyc();
        aresetn = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cyc();
            din = ONES;
            check("post_rst_idle", 128'(busy), 128'(1'b0));
            check("post_rst_valid", 128'(m_axis_tvalid), 128'(1'b0));
        end
        din = '0;
        cyc();
        check("beats_outstanding", 128'(exp_q.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
